fpmul_arb: RTL and testbench

Two-port arbiter and sequencer that shares one pipelined floating-point multiplier (`fpmulti`, fixed latency `MUL_LAT`) between two requesters. It accepts operand pairs on valid/ready handshakes and issues at most one pair per cycle using round-robin arbitration. A tag travels alongside each operation through the multiplier pipeline, and each product is steered into a per-requester result FIFO. Issue is credit-gated, so a product never arrives at a full FIFO; the multiplier needs no stall input.

---
 rtl/fpmul_pkg.sv | 40 ++++
 rtl/fpmul_res_fifo.sv | 93 +++++++++
 rtl/fpmul_arb.sv | 155 +++++++++++++++
 tb/tb_fpmul_arb.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_pkg.sv
// -----------------------------------------------------------------------------
// fpmul_pkg
// Shared definitions for the two-port multiplier arbiter:
//   - floating-point word field positions (data is carried untouched)
//   - number of requesters and word width
//   - tag carried alongside each operation through the multiplier pipeline
//   - round-robin pick helper used by the arbiter
// -----------------------------------------------------------------------------
package fpmul_pkg;

    // Word layout: sign in bit 0, exponent in 8:1, mantissa in 31:9
    localparam int SIGN_BIT = 0;
    localparam int EXP_LSB  = 1;
    localparam int EXP_MSB  = 8;
    localparam int MAN_LSB  = 9;
    localparam int MAN_MSB  = 31;

    localparam int WORD_W   = 32;
    localparam int NUM_REQ  = 2;

    // Tag travelling with each issued operation
    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    // One-hot grant from eligibility; ptr selects the winner on a tie
    function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                                   input logic               ptr);
        logic [NUM_REQ-1:0] grant;
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

endpackage

// File: rtl/fpmul_res_fifo.sv
// -----------------------------------------------------------------------------
// fpmul_res_fifo
// Synchronous 32-bit result FIFO with occupancy output.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push_i     : write data_i this cycle (never issued while full unless a
//                pop happens in the same cycle; the upstream credit scheme
//                guarantees this)
//   data_i     : write data
//   pop_i      : consume head entry; ignored when empty
//   data_o     : head entry, 0 when empty
//   valid_o    : FIFO non-empty
//   count_o    : number of stored entries
// -----------------------------------------------------------------------------
module fpmul_res_fifo
    import fpmul_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [WORD_W-1:0] data_i,
    input  logic              pop_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_s;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = {PTR_W{1'b0}};
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // Next-state for pointers and occupancy; push and pop may coincide
    always_comb begin
        pop_s    = pop_i && (count_q != {CNT_W{1'b0}});
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        case ({push_i, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Head output forced to 0 when empty so the outputs read 0 during reset
    always_comb begin
        valid_o = (count_q != {CNT_W{1'b0}});
        count_o = count_q;
        if (valid_o) begin
            data_o = mem_q[rd_ptr_q];
        end else begin
            data_o = {WORD_W{1'b0}};
        end
    end

endmodule

// File: rtl/fpmul_arb.sv
// -----------------------------------------------------------------------------
// fpmul_arb
// Shares one pipelined multiplier (fixed latency MUL_LAT) between two
// requesters. Round-robin arbitration, credit-gated issue so a product never
// meets a full result FIFO, tag pipeline steering products to per-requester
// result FIFOs.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   req_valid[1:0]         : requester i presents operands
//   req_ready[1:0]         : one-hot grant (combinational)
//   req_a0/b0, req_a1/b1   : operands of requester 0 / 1
//   mul_vld, mul_a, mul_b  : issue strobe and operands to the multiplier
//   mul_out                : multiplier product, MUL_LAT cycles after issue
//   res_valid[1:0]         : result FIFO i non-empty
//   res_ready[1:0]         : requester i consumes its head result
//   res_data0/1            : head of result FIFO 0 / 1
// -----------------------------------------------------------------------------
module fpmul_arb
    import fpmul_pkg::*;
#(
    parameter int MUL_LAT   = 2,
    parameter int RES_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [WORD_W-1:0]  req_a0,
    input  logic [WORD_W-1:0]  req_b0,
    input  logic [WORD_W-1:0]  req_a1,
    input  logic [WORD_W-1:0]  req_b1,
    output logic               mul_vld,
    output logic [WORD_W-1:0]  mul_a,
    output logic [WORD_W-1:0]  mul_b,
    input  logic [WORD_W-1:0]  mul_out,
    output logic [NUM_REQ-1:0] res_valid,
    input  logic [NUM_REQ-1:0] res_ready,
    output logic [WORD_W-1:0]  res_data0,
    output logic [WORD_W-1:0]  res_data1
);

    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;

    logic               rr_q, rr_d;
    logic [CNT_W-1:0]   inflight_q [NUM_REQ];
    logic [CNT_W-1:0]   inflight_d [NUM_REQ];
    logic [CNT_W-1:0]   fifo_cnt_s [NUM_REQ];
    tag_t               tag_q      [MUL_LAT];
    tag_t               tag_last_s;
    logic [NUM_REQ-1:0] elig_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [NUM_REQ-1:0] push_s;
    logic [NUM_REQ-1:0] pop_s;
    logic               win_id_s;
    logic [SUM_W-1:0]   used_s     [NUM_REQ];

    // Credit check and round-robin grant. Grant is held off while rst is
    // high so all combinational outputs read 0 during reset.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            used_s[i] = SUM_W'(inflight_q[i]) + SUM_W'(fifo_cnt_s[i]);
            elig_s[i] = req_valid[i] && (used_s[i] < SUM_W'(RES_DEPTH));
        end
        if (rst) begin
            grant_s = {NUM_REQ{1'b0}};
        end else begin
            grant_s = rr_pick(elig_s, rr_q);
        end
        win_id_s  = grant_s[1];
        req_ready = grant_s;
        mul_vld   = |grant_s;
        if (grant_s[0]) begin
            mul_a = req_a0;
            mul_b = req_b0;
        end else if (grant_s[1]) begin
            mul_a = req_a1;
            mul_b = req_b1;
        end else begin
            mul_a = {WORD_W{1'b0}};
            mul_b = {WORD_W{1'b0}};
        end
        // Pointer moves to the loser after a grant
        if (mul_vld) begin
            rr_d = ~win_id_s;
        end else begin
            rr_d = rr_q;
        end
    end

    // Product steering and per-requester in-flight accounting
    always_comb begin
        tag_last_s = tag_q[MUL_LAT-1];
        pop_s      = res_valid & res_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            push_s[i] = tag_last_s.vld && (tag_last_s.id == 1'(i));
            case ({grant_s[i], push_s[i]})
                2'b10:   inflight_d[i] = inflight_q[i] + CNT_W'(1);
                2'b01:   inflight_d[i] = inflight_q[i] - CNT_W'(1);
                default: inflight_d[i] = inflight_q[i];
            endcase
        end
    end

    // Arbiter pointer, in-flight counters and tag pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                inflight_q[i] <= {CNT_W{1'b0}};
            end
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_q[k] <= '{vld: 1'b0, id: 1'b0};
            end
        end else begin
            rr_q <= rr_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                inflight_q[i] <= inflight_d[i];
            end
            tag_q[0] <= '{vld: mul_vld, id: win_id_s};
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    fpmul_res_fifo #(
        .DEPTH (RES_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s[0]),
        .data_i  (mul_out),
        .pop_i   (pop_s[0]),
        .data_o  (res_data0),
        .valid_o (res_valid[0]),
        .count_o (fifo_cnt_s[0])
    );

    fpmul_res_fifo #(
        .DEPTH (RES_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s[1]),
        .data_i  (mul_out),
        .pop_i   (pop_s[1]),
        .data_o  (res_data1),
        .valid_o (res_valid[1]),
        .count_o (fifo_cnt_s[1])
    );

endmodule

// File: tb/tb_fpmul_arb.sv
// -----------------------------------------------------------------------------
// tb_fpmul_arb
// Bench for fpmul_arb with a stub multiplier returning mul_a ^ mul_b two
// cycles later. The reference model keeps, per requester, a queue of accepted
// operations not yet consumed (expected product + cycle it becomes visible);
// its length is the credit in use.
// -----------------------------------------------------------------------------
module tb_fpmul_arb;

    localparam int MUL_LAT   = 2;
    localparam int RES_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_a0 = 32'h0, req_b0 = 32'h0, req_a1 = 32'h0, req_b1 = 32'h0;
    logic        mul_vld;
    logic [31:0] mul_a, mul_b, mul_out;
    logic [1:0]  res_valid;
    logic [1:0]  res_ready = 2'b00;
    logic [31:0] res_data0, res_data1;

    fpmul_arb #(.MUL_LAT(MUL_LAT), .RES_DEPTH(RES_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .mul_vld(mul_vld), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data0(res_data0), .res_data1(res_data1)
    );

    always #5 clk = ~clk;

    // Stub multiplier: two register stages
    logic [31:0] p1_q;
    always @(posedge clk) begin
        p1_q    <= mul_a ^ mul_b;
        mul_out <= p1_q;
    end

    typedef struct {
        logic [31:0] d;
        int          rdy;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    logic rr_m = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [1:0]  obs_ready, obs_valid;
    logic [31:0] obs_d0, obs_d1;

    task automatic model_reset();
        q0.delete();
        q1.delete();
        rr_m = 1'b0;
    endtask

    // One clock cycle: compare all outputs with the model at the falling
    // edge, then advance the model with the handshakes that take place.
    task automatic step();
        logic [1:0]  el, g, ev;
        logic [31:0] ea, eb;
        @(negedge clk);
        el[0] = req_valid[0] && (q0.size() < RES_DEPTH);
        el[1] = req_valid[1] && (q1.size() < RES_DEPTH);
        if (el == 2'b11) g = rr_m ? 2'b10 : 2'b01;
        else             g = el;
        if (g[0])      begin ea = req_a0; eb = req_b0; end
        else if (g[1]) begin ea = req_a1; eb = req_b1; end
        else           begin ea = 32'h0;  eb = 32'h0;  end
        ev[0] = (q0.size() > 0) && (q0[0].rdy <= cyc);
        ev[1] = (q1.size() > 0) && (q1[0].rdy <= cyc);

        n_checks++;
        if (req_ready !== g) begin
            n_fail++;
            $display("FAIL req_ready cyc=%0d got %b want %b", cyc, req_ready, g);
        end
        n_checks++;
        if (mul_vld !== (|g) || mul_a !== ea || mul_b !== eb) begin
            n_fail++;
            $display("FAIL mul_issue cyc=%0d got vld=%b a=%h b=%h want vld=%b a=%h b=%h",
                     cyc, mul_vld, mul_a, mul_b, |g, ea, eb);
        end
        n_checks++;
        if (res_valid !== ev) begin
            n_fail++;
            $display("FAIL res_valid cyc=%0d got %b want %b", cyc, res_valid, ev);
        end
        if (ev[0]) begin
            n_checks++;
            if (res_data0 !== q0[0].d) begin
                n_fail++;
                $display("FAIL res_data0 cyc=%0d got %h want %h", cyc, res_data0, q0[0].d);
            end
        end
        if (ev[1]) begin
            n_checks++;
            if (res_data1 !== q1[0].d) begin
                n_fail++;
                $display("FAIL res_data1 cyc=%0d got %h want %h", cyc, res_data1, q1[0].d);
            end
        end
        obs_ready = req_ready;
        obs_valid = res_valid;
        obs_d0    = res_data0;
        obs_d1    = res_data1;

        @(posedge clk);
        if (ev[0] && res_ready[0]) void'(q0.pop_front());
        if (ev[1] && res_ready[1]) void'(q1.pop_front());
        if (g[0]) q0.push_back('{d: req_a0 ^ req_b0, rdy: cyc + MUL_LAT + 1});
        if (g[1]) q1.push_back('{d: req_a1 ^ req_b1, rdy: cyc + MUL_LAT + 1});
        if (g != 2'b00) rr_m = g[0];
        cyc++;
        #1;
    endtask

    task automatic drain();
        req_valid = 2'b00;
        res_ready = 2'b11;
        for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) step();
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL drain left %0d/%0d results pending", q0.size(), q1.size());
        end
        res_ready = 2'b00;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        // Build up some state so outputs are non-zero before reset
        req_valid = 2'b11;
        res_ready = 2'b00;
        req_a0 = 32'h1234_0000; req_b0 = 32'h0000_5678;
        req_a1 = 32'hAAAA_0000; req_b1 = 32'h0000_5555;
        repeat (4) step();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (req_ready !== 2'b00 || mul_vld !== 1'b0 || mul_a !== 32'h0 || mul_b !== 32'h0 ||
            res_valid !== 2'b00 || res_data0 !== 32'h0 || res_data1 !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%b vld=%b a=%h b=%h rv=%b d0=%h d1=%h want all 0",
                     req_ready, mul_vld, mul_a, mul_b, res_valid, res_data0, res_data1);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = 2'b10;
        step();
        n_checks++;
        if (obs_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL first_grant_after_reset got %b want 10", obs_ready);
        end
        drain();
    endtask

    task automatic test_contention();
        logic [1:0] grants [12];
        req_valid = 2'b11;
        res_ready = 2'b11;
        for (int k = 0; k < 12; k++) begin
            req_a0 = $urandom; req_b0 = $urandom;
            req_a1 = $urandom; req_b1 = $urandom;
            step();
            grants[k] = obs_ready;
        end
        for (int k = 0; k < 12; k++) begin
            n_checks++;
            if (grants[k] !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL contention_alternate k=%0d got %b want %b",
                         k, grants[k], (k % 2 == 0) ? 2'b01 : 2'b10);
            end
        end
        drain();
    endtask

    task automatic test_single_op();
        req_a0 = 32'h0000_00FE;
        req_b0 = 32'h0000_0100;
        req_valid = 2'b01;
        res_ready = 2'b00;
        step();
        req_valid = 2'b00;
        step();
        step();
        n_checks++;
        if (obs_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL single_op_early got res_valid=%b want 00 at t+2", obs_valid);
        end
        step();
        n_checks++;
        if (obs_valid !== 2'b01 || obs_d0 !== 32'h0000_01FE) begin
            n_fail++;
            $display("FAIL single_op got res_valid=%b data0=%h want 01 / 000001fe", obs_valid, obs_d0);
        end
        drain();
    endtask

    task automatic test_credit_stall();
        int acc;
        req_valid = 2'b01;
        res_ready = 2'b00;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            req_a0 = $urandom; req_b0 = $urandom;
            step();
            if (obs_ready[0]) acc++;
        end
        n_checks++;
        if (acc != 2) begin
            n_fail++;
            $display("FAIL credit_stall_accepts got %0d want 2", acc);
        end
        res_ready = 2'b01;
        step();
        res_ready = 2'b00;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (obs_ready[0]) acc++;
        end
        n_checks++;
        if (acc != 1) begin
            n_fail++;
            $display("FAIL credit_release_accepts got %0d want 1", acc);
        end
        drain();
    endtask

    task automatic test_push_pop();
        logic [31:0] second;
        req_valid = 2'b01;
        res_ready = 2'b00;
        req_a0 = 32'h1111_0000; req_b0 = 32'h0000_2222;
        step();
        req_a0 = 32'h3333_0000; req_b0 = 32'h0000_4444;
        second = 32'h3333_4444;
        step();
        req_valid = 2'b00;
        step();
        res_ready = 2'b01;
        step();
        res_ready = 2'b00;
        step();
        n_checks++;
        if (obs_valid[0] !== 1'b1 || obs_d0 !== second) begin
            n_fail++;
            $display("FAIL push_pop got valid=%b data0=%h want 1 / %h", obs_valid[0], obs_d0, second);
        end
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            req_valid = 2'($urandom_range(0, 3));
            res_ready = 2'($urandom_range(0, 3));
            req_a0 = $urandom; req_b0 = $urandom;
            req_a1 = $urandom; req_b1 = $urandom;
            step();
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        int acc;
        req_valid = 2'b01;
        res_ready = 2'b00;
        req_a0 = 32'hDEAD_0000; req_b0 = 32'h0000_BEEF;
        step();
        step();
        req_valid = 2'b00;
        step();
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        res_ready = 2'b01;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (obs_valid != 2'b00) acc++;
        end
        n_checks++;
        if (acc != 0) begin
            n_fail++;
            $display("FAIL midflight_no_result got %0d cycles with results want 0", acc);
        end
        req_valid = 2'b01;
        res_ready = 2'b00;
        acc = 0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (obs_ready[0]) acc++;
        end
        n_checks++;
        if (acc != 2) begin
            n_fail++;
            $display("FAIL midflight_fresh_accepts got %0d want 2", acc);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single_op();
        test_credit_stall();
        test_push_pop();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
